// File: rtl/pkt_decode_pkg.sv
// Shared types and constants for the packet frame decoder.
// ST_CSUM exists only when PKT_DECODE_CHECKSUM_EN is defined.
package pkt_decode_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD
`ifdef PKT_DECODE_CHECKSUM_EN
    ,
    ST_CSUM
`endif
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

  localparam logic [31:0] DEF_RESYNC_WORD = 32'h1EDC6F41;
  localparam logic [31:0] DEF_SOP_WORD    = 32'h741B8CD7;

endpackage

// File: rtl/pkt_word_timeout.sv
// Idle-cycle counter between words; expires after TIMEOUT_CYCLES.
// TIMEOUT_CYCLES == 0 builds no counter and never expires.
module pkt_word_timeout #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  generate
    if (TIMEOUT_CYCLES == 24'd0) begin : g_off
      assign o_expire = 1'b0;
    end else begin : g_on
      logic [23:0] count;

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          count <= '0;
        end else if (i_clear) begin
          count <= '0;
        end else if (i_enable) begin
          count <= count + 24'd1;
        end
      end

      // fires during the TIMEOUT_CYCLES-th idle cycle
      assign o_expire = i_enable && !i_clear &&
                        (count == TIMEOUT_CYCLES - 24'd1);
    end
  endgenerate

endmodule

// File: rtl/pkt_frame_decoder.sv
// Word-level packet decoder: SOP, command, length, payload stream.
// Define PKT_DECODE_CHECKSUM_EN to add a trailing XOR checksum word.
module pkt_frame_decoder
  import pkt_decode_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter logic [DATA_W-1:0] RESYNC_WORD    = DATA_W'(DEF_RESYNC_WORD),
  parameter logic [DATA_W-1:0] SOP_WORD       = DATA_W'(DEF_SOP_WORD),
  parameter int                CMD_W          = 2,
  parameter int                CMD_LSB        = 24,
  parameter int                LEN_W          = 16,
  parameter logic [LEN_W-1:0]  MAX_LEN        = 16'd4096,
  parameter bit                LEN_BYTESWAP   = 1'b1,
  parameter logic [23:0]       TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_recv_word_cmd,
  input  logic [DATA_W-1:0] i_recv_word_data,
  output logic [CMD_W-1:0]  o_packet_command,
  output logic [DATA_W-1:0] o_payload_data_word,
  output logic              o_payload_word_recv,
  output logic              o_payload_last,
  output logic              o_packet_fully_decoded,
  output logic              o_packet_error,
  output logic [1:0]        o_error_code,
  output logic              o_reset,
  output logic              o_busy
);

  state_t            state;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  len_val;
  logic              tmo_expire;
  logic              is_resync;
`ifdef PKT_DECODE_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  assign is_resync = i_recv_word_cmd &&
                     (i_recv_word_data == RESYNC_WORD);

  // little-endian host: byte 0 of the length sits in the top byte
  always_comb begin
    len_val = i_recv_word_data[LEN_W-1:0];
    if (LEN_BYTESWAP) begin
      for (int i = 0; i < LEN_W / 8; i++) begin
        len_val[8*i +: 8] = i_recv_word_data[DATA_W-8-8*i +: 8];
      end
    end
  end

  pkt_word_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_recv_word_cmd || state == ST_IDLE),
    .i_enable(state != ST_IDLE),
    .o_expire(tmo_expire)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state                  <= ST_IDLE;
      remaining              <= '0;
      o_packet_command       <= '0;
      o_payload_data_word    <= '0;
      o_payload_word_recv    <= 1'b0;
      o_payload_last         <= 1'b0;
      o_packet_fully_decoded <= 1'b0;
      o_packet_error         <= 1'b0;
      o_error_code           <= ERR_NONE;
      o_reset                <= 1'b0;
      o_busy                 <= 1'b0;
`ifdef PKT_DECODE_CHECKSUM_EN
      csum                   <= '0;
`endif
    end else begin
      o_payload_word_recv    <= 1'b0;
      o_payload_last         <= 1'b0;
      o_packet_fully_decoded <= 1'b0;
      o_packet_error         <= 1'b0;
      o_reset                <= 1'b0;
      if (is_resync) begin
        state   <= ST_IDLE;
        o_busy  <= 1'b0;
        o_reset <= 1'b1;
      end else if (tmo_expire) begin
        state          <= ST_IDLE;
        o_busy         <= 1'b0;
        o_packet_error <= 1'b1;
        o_error_code   <= ERR_TIMEOUT;
      end else if (i_recv_word_cmd) begin
        unique case (state)
          ST_IDLE: begin
            if (i_recv_word_data == SOP_WORD) begin
              state  <= ST_CMD;
              o_busy <= 1'b1;
            end
          end
          ST_CMD: begin
            o_packet_command <= i_recv_word_data[CMD_LSB +: CMD_W];
            state            <= ST_LEN;
          end
          ST_LEN: begin
`ifdef PKT_DECODE_CHECKSUM_EN
            csum <= '0;
`endif
            if (len_val > MAX_LEN) begin
              state          <= ST_IDLE;
              o_busy         <= 1'b0;
              o_packet_error <= 1'b1;
              o_error_code   <= ERR_LEN;
            end else if (len_val == '0) begin
`ifdef PKT_DECODE_CHECKSUM_EN
              state <= ST_CSUM;
`else
              state                  <= ST_IDLE;
              o_busy                 <= 1'b0;
              o_packet_fully_decoded <= 1'b1;
`endif
            end else begin
              remaining <= len_val;
              state     <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            o_payload_word_recv <= 1'b1;
            o_payload_data_word <= i_recv_word_data;
            remaining           <= remaining - LEN_W'(1);
`ifdef PKT_DECODE_CHECKSUM_EN
            csum <= csum ^ i_recv_word_data;
`endif
            if (remaining == LEN_W'(1)) begin
              o_payload_last <= 1'b1;
`ifdef PKT_DECODE_CHECKSUM_EN
              state <= ST_CSUM;
`else
              state                  <= ST_IDLE;
              o_busy                 <= 1'b0;
              o_packet_fully_decoded <= 1'b1;
`endif
            end
          end
`ifdef PKT_DECODE_CHECKSUM_EN
          ST_CSUM: begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
            if (i_recv_word_data == csum) begin
              o_packet_fully_decoded <= 1'b1;
            end else begin
              o_packet_error <= 1'b1;
              o_error_code   <= ERR_CSUM;
            end
          end
`endif
          default: begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pkt_frame_decoder.sv
// Directed bench for pkt_frame_decoder with an event scoreboard.
// Also covers the PKT_DECODE_CHECKSUM_EN build when that macro is set.
module tb_pkt_frame_decoder;
  import pkt_decode_pkg::*;

`ifdef PKT_DECODE_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam logic [31:0] SOP = 32'h741B8CD7;
  localparam logic [31:0] RSY = 32'h1EDC6F41;

  typedef struct packed {
    logic [31:0] cyc;
    logic        recv;
    logic [31:0] data;
    logic        last;
    logic        done;
    logic        err;
    logic [1:0]  code;
    logic        rst;
  } ev_t;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_recv_word_cmd;
  logic [31:0] i_recv_word_data;
  logic [1:0]  o_packet_command;
  logic [31:0] o_payload_data_word;
  logic        o_payload_word_recv;
  logic        o_payload_last;
  logic        o_packet_fully_decoded;
  logic        o_packet_error;
  logic [1:0]  o_error_code;
  logic        o_reset;
  logic        o_busy;

  ev_t         exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] cyc = '0;
  logic [31:0] acc;
  logic [31:0] t0;

  pkt_frame_decoder #(
    .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .i_clk                 (i_clk),
    .i_reset               (i_reset),
    .i_recv_word_cmd       (i_recv_word_cmd),
    .i_recv_word_data      (i_recv_word_data),
    .o_packet_command      (o_packet_command),
    .o_payload_data_word   (o_payload_data_word),
    .o_payload_word_recv   (o_payload_word_recv),
    .o_payload_last        (o_payload_last),
    .o_packet_fully_decoded(o_packet_fully_decoded),
    .o_packet_error        (o_packet_error),
    .o_error_code          (o_error_code),
    .o_reset               (o_reset),
    .o_busy                (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 32'd1;

  // every pulse must match the next expected event, cycle-exact
  always @(negedge i_clk) begin
    ev_t obs;
    ev_t e;
    if (!i_reset && (o_payload_word_recv || o_packet_fully_decoded ||
                     o_packet_error || o_reset)) begin
      obs.cyc  = cyc;
      obs.recv = o_payload_word_recv;
      obs.data = o_payload_word_recv ? o_payload_data_word : 32'h0;
      obs.last = o_payload_last;
      obs.done = o_packet_fully_decoded;
      obs.err  = o_packet_error;
      obs.code = o_packet_error ? o_error_code : 2'd0;
      obs.rst  = o_reset;
      e = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      checks++;
      assert (obs === e) else begin
        failures++;
        $error("FAIL event observed=%h expected=%h", obs, e);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] at, input logic recv,
                      input logic [31:0] d, input logic last,
                      input logic done, input logic err,
                      input logic [1:0] code, input logic rst);
    ev_t e;
    e.cyc  = at;
    e.recv = recv;
    e.data = d;
    e.last = last;
    e.done = done;
    e.err  = err;
    e.code = code;
    e.rst  = rst;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] w);
    i_recv_word_cmd  = 1'b1;
    i_recv_word_data = w;
    @(posedge i_clk);
    #1;
    i_recv_word_cmd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic start(input logic [31:0] cmd_w, input logic [31:0] len_w);
    send(SOP);
    send(cmd_w);
    acc = '0;
    send(len_w);
  endtask

  task automatic pay(input logic [31:0] w, input logic last);
    acc = acc ^ w;
    push(cyc + 1, 1'b1, w, last, last & !CSUM, 1'b0, 2'd0, 1'b0);
    send(w);
  endtask

  task automatic finish_pkt();
    if (CSUM) begin
      push(cyc + 1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
      send(acc);
    end
  endtask

  task automatic check_quiet(input string tag);
    check(tag, {o_packet_command, o_payload_data_word,
                o_payload_word_recv, o_payload_last,
                o_packet_fully_decoded, o_packet_error,
                o_error_code, o_reset, o_busy}, 64'h0);
  endtask

  initial begin
    i_reset          = 1'b1;
    i_recv_word_cmd  = 1'b0;
    i_recv_word_data = '0;
    idle(2);
    check_quiet("reset_state");
    i_reset = 1'b0;
    idle(1);

    // basic 3-word packet, byte-swapped length
    start(32'h0100_0000, 32'h0300_0000);
    check("busy_in_payload", 64'(o_busy), 64'd1);
    pay(32'hAAAA_0001, 1'b0);
    pay(32'hBBBB_0002, 1'b0);
    pay(32'hCCCC_0003, 1'b1);
    finish_pkt();
    idle(2);
    check("cmd_pkt1", 64'(o_packet_command), 64'd1);
    check("busy_idle_pkt1", 64'(o_busy), 64'd0);

    // zero-length packet
    send(SOP);
    send(32'h0200_0000);
    if (!CSUM) begin
      push(cyc + 1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
      send(32'h0);
    end else begin
      send(32'h0);
      push(cyc + 1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
      send(32'h0);
    end
    idle(2);
    check("cmd_zero_len", 64'(o_packet_command), 64'd2);

    // length 4097 > MAX_LEN
    send(SOP);
    send(32'h0300_0000);
    push(cyc + 1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, ERR_LEN, 1'b0);
    send(32'h0110_0000);
    idle(3);
    check("code_len", 64'(o_error_code), 64'd1);
    check("busy_after_len", 64'(o_busy), 64'd0);

    // length exactly MAX_LEN is accepted
    start(32'h0000_0000, 32'h0010_0000);
    for (int i = 0; i < 4096; i++) pay(32'(i) ^ 32'h5A00_0000, i == 4095);
    finish_pkt();
    idle(2);
    check("busy_after_max", 64'(o_busy), 64'd0);

    // inter-word timeout after 2 of 5 words
    start(32'h0300_0000, 32'h0500_0000);
    pay(32'h1111_1111, 1'b0);
    pay(32'h2222_2222, 1'b0);
    push(cyc + 100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, ERR_TIMEOUT, 1'b0);
    idle(105);
    check("code_timeout", 64'(o_error_code), 64'd2);
    check("busy_after_tmo", 64'(o_busy), 64'd0);
    start(32'h0000_0000, 32'h0200_0000);
    pay(32'h3333_3333, 1'b0);
    pay(32'h4444_4444, 1'b1);
    finish_pkt();
    idle(2);
    check("cmd_after_tmo", 64'(o_packet_command), 64'd0);
    check("code_held", 64'(o_error_code), 64'd2);

    // RESYNC as third payload word, SOP right after
    start(32'h0100_0000, 32'h0500_0000);
    pay(32'h0000_00A1, 1'b0);
    pay(32'h0000_00A2, 1'b0);
    push(cyc + 1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    send(RSY);
    check("busy_after_rsy", 64'(o_busy), 64'd0);
    start(32'h0200_0000, 32'h0100_0000);
    pay(32'hFEED_F00D, 1'b1);
    finish_pkt();
    idle(2);
    check("cmd_after_rsy", 64'(o_packet_command), 64'd2);

    // SOP value inside payload is plain data
    start(32'h0300_0000, 32'h0200_0000);
    pay(SOP, 1'b0);
    pay(32'h0000_0055, 1'b1);
    finish_pkt();
    idle(2);
    check("cmd_sop_data", 64'(o_packet_command), 64'd3);

    // RESYNC on the very cycle the timeout would expire
    start(32'h0100_0000, 32'h0200_0000);
    pay(32'h0000_0077, 1'b0);
    t0 = cyc;
    idle(99);
    push(t0 + 100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    send(RSY);
    idle(3);
    check("code_no_err", 64'(o_error_code), 64'd2);

    // reset mid-packet aborts silently
    start(32'h0100_0000, 32'h0300_0000);
    pay(32'h0000_0099, 1'b0);
    idle(1);
    i_reset = 1'b1;
    idle(1);
    check_quiet("reset_mid_pkt");
    i_reset = 1'b0;
    idle(1);
    start(32'h0200_0000, 32'h0100_0000);
    pay(32'h0BAD_CAFE, 1'b1);
    finish_pkt();
    idle(2);
    check("cmd_after_reset", 64'(o_packet_command), 64'd2);

`ifdef PKT_DECODE_CHECKSUM_EN
    start(32'h0100_0000, 32'h0200_0000);
    pay(32'h0000_000F, 1'b0);
    pay(32'h0000_00F0, 1'b1);
    push(cyc + 1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    send(32'h0000_00FF);
    start(32'h0100_0000, 32'h0200_0000);
    pay(32'h0000_000F, 1'b0);
    pay(32'h0000_00F0, 1'b1);
    push(cyc + 1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, ERR_CSUM, 1'b0);
    send(32'h0000_00FE);
    idle(2);
    check("code_csum", 64'(o_error_code), 64'd3);
`endif

    idle(5);
    check("events_pending", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
